// File: rtl/voice_allocator.sv
// Note-on/off allocator for the polyphonic synth: assigns events to voice slots and hands each
// configuration update to the CPU-to-synth CDC via 4-phase req/ack. Optional macro: VOICE_STEAL_EN.
module voice_allocator #(
  parameter int N_VOICES  = 4,
  parameter int FCW_WIDTH = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          note_valid,
  output logic                          note_ready,
  input  logic                          note_on,
  input  logic [FCW_WIDTH-1:0]          note_fcw,
  output logic [N_VOICES*FCW_WIDTH-1:0] carrier_fcws,
  output logic [N_VOICES-1:0]           note_en,
  output logic                          req,
  input  logic                          ack,
  output logic                          drop
);

  // Ages need to represent N_VOICES, the "old age" of a free voice.
  localparam int AGE_W = $clog2(N_VOICES + 1);

  typedef enum logic [2:0] {DRAIN, IDLE, ALLOC, REQ, WAIT_LO} state_t;

  state_t                        state, state_nxt;
  logic                          lat_on;
  logic [FCW_WIDTH-1:0]          lat_fcw;
  logic [AGE_W-1:0]              age     [N_VOICES];
  logic [AGE_W-1:0]              age_nxt [N_VOICES];
  logic [N_VOICES*FCW_WIDTH-1:0] fcws_nxt;
  logic [N_VOICES-1:0]           en_nxt;
  logic                          issue;
  logic                          hit, free;
  int                            hit_idx, free_idx;
`ifdef VOICE_STEAL_EN
  logic                          old;
  int                            old_idx;
`endif

  // Lowest index wins: scan downward so later matches overwrite earlier ones.
  always_comb begin
    hit = 1'b0; hit_idx = 0; free = 1'b0; free_idx = 0;
`ifdef VOICE_STEAL_EN
    old = 1'b0; old_idx = 0;
`endif
    for (int i = N_VOICES - 1; i >= 0; i--) begin
      if (note_en[i] && carrier_fcws[i*FCW_WIDTH +: FCW_WIDTH] == lat_fcw) begin
        hit = 1'b1; hit_idx = i;
      end
      if (!note_en[i]) begin
        free = 1'b1; free_idx = i;
      end
`ifdef VOICE_STEAL_EN
      if (note_en[i] && age[i] == AGE_W'(N_VOICES - 1)) begin
        old = 1'b1; old_idx = i;
      end
`endif
    end
  end

  always_comb begin
    logic             sel;
    int               sel_idx;
    logic [AGE_W-1:0] sel_age;
    en_nxt   = note_en;
    fcws_nxt = carrier_fcws;
    age_nxt  = age;
    issue    = 1'b0;
    sel      = 1'b0;
    sel_idx  = 0;
    sel_age  = AGE_W'(N_VOICES);
    if (lat_on) begin
      if (hit) begin
        sel = 1'b1; sel_idx = hit_idx; sel_age = age[hit_idx];
      end else if (free) begin
        sel = 1'b1; sel_idx = free_idx;
      end
`ifdef VOICE_STEAL_EN
      else if (old) begin
        sel = 1'b1; sel_idx = old_idx; sel_age = age[old_idx];
      end
`endif
      if (sel) begin
        for (int i = 0; i < N_VOICES; i++)
          if (i != sel_idx && note_en[i] && age[i] < sel_age) age_nxt[i] = age[i] + 1'b1;
        age_nxt[sel_idx] = '0;
        en_nxt[sel_idx]  = 1'b1;
        fcws_nxt[sel_idx*FCW_WIDTH +: FCW_WIDTH] = lat_fcw;
        issue = 1'b1;
      end
    end else if (hit) begin
      // Close the age gap left by the released voice so enabled ages stay 0..k-1.
      for (int i = 0; i < N_VOICES; i++)
        if (i != hit_idx && note_en[i] && age[i] > age[hit_idx]) age_nxt[i] = age[i] - 1'b1;
      en_nxt[hit_idx] = 1'b0;
      issue = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DRAIN:   if (!ack) state_nxt = IDLE;
      IDLE:    if (note_valid) state_nxt = ALLOC;
      ALLOC:   state_nxt = issue ? REQ : IDLE;
      REQ:     if (ack && req) state_nxt = WAIT_LO;
      WAIT_LO: if (!ack) state_nxt = IDLE;
      default: state_nxt = DRAIN;
    endcase
  end

  assign note_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= DRAIN;
      carrier_fcws <= '0;
      note_en      <= '0;
      req          <= 1'b0;
      drop         <= 1'b0;
      for (int i = 0; i < N_VOICES; i++) age[i] <= '0;
    end else begin
      state <= state_nxt;
      drop  <= (state == ALLOC) && !issue;
      if (state == ALLOC) begin
        note_en      <= en_nxt;
        carrier_fcws <= fcws_nxt;
        age          <= age_nxt;
      end
      req <= (state == REQ) && !(ack && req);
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && note_valid) begin
      lat_on  <= note_on;
      lat_fcw <= note_fcw;
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator (N_VOICES=4, FCW_WIDTH=24); expectations follow VOICE_STEAL_EN.
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        note_valid = 1'b0;
  logic        note_ready;
  logic        note_on = 1'b0;
  logic [23:0] note_fcw = '0;
  logic [95:0] carrier_fcws;
  logic [3:0]  note_en;
  logic        req;
  logic        ack = 1'b0;
  logic        drop;

  int checks = 0;
  int errors = 0;

  voice_allocator #(.N_VOICES(4), .FCW_WIDTH(24)) dut (
    .clk(clk), .rst(rst), .note_valid(note_valid), .note_ready(note_ready),
    .note_on(note_on), .note_fcw(note_fcw), .carrier_fcws(carrier_fcws),
    .note_en(note_en), .req(req), .ack(ack), .drop(drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst_before;
    bit          on;
    logic [23:0] fcw;
    bit          upd;
    logic [3:0]  en;
    logic [95:0] fcws;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit on, logic [23:0] fcw, bit upd, logic [3:0] en,
                              logic [23:0] v3, logic [23:0] v2, logic [23:0] v1, logic [23:0] v0);
    vec_t v;
    v.rst_before = r; v.on = on; v.fcw = fcw; v.upd = upd; v.en = en;
    v.fcws = {v3, v2, v1, v0};
    return v;
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Offer one event and run the handshake; ack is raised 3 cycles after req rises.
  task automatic do_event(input bit on, input logic [23:0] fcw, output bit got_req, output bit got_drop);
    int n = 0;
    got_req = 1'b0; got_drop = 1'b0;
    while (!note_ready && n < 30) begin @(posedge clk); #1; n++; end
    if (!note_ready) begin
      check("ready_timeout", 96'(note_ready), 96'd1);
      return;
    end
    note_valid = 1'b1; note_on = on; note_fcw = fcw;
    @(posedge clk); #1;
    note_valid = 1'b0;
    @(posedge clk); #1;
    got_drop = drop;
    check("req_low_at_alloc_plus1", 96'(req), 96'd0);
    if (drop) check("ready_after_drop", 96'(note_ready), 96'd1);
    @(posedge clk); #1;
    got_req = req;
    if (got_drop) check("drop_one_cycle", 96'(drop), 96'd0);
    if (got_req) begin
      repeat (3) @(posedge clk);
      #1;
      check("req_held", 96'(req), 96'd1);
      ack = 1'b1;
      @(posedge clk); #1;
      check("req_fall_after_ack", 96'(req), 96'd0);
      check("ready_low_wait_lo", 96'(note_ready), 96'd0);
      ack = 1'b0;
      @(posedge clk); #1;
      check("ready_after_ack_low", 96'(note_ready), 96'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit gr, gd;
    // Reset with ack stuck high: must stay in DRAIN until ack drops.
    rst = 1'b1; ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 96'(note_ready), 96'd0);
    check("rst_req", 96'(req), 96'd0);
    check("rst_en", 96'(note_en), 96'd0);
    check("rst_fcws", carrier_fcws, 96'd0);
    check("rst_drop", 96'(drop), 96'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("drain_ready", 96'(note_ready), 96'd0);
      check("drain_req", 96'(req), 96'd0);
    end
    ack = 1'b0;
    check("drain_ready_before_edge", 96'(note_ready), 96'd0);
    @(posedge clk); #1;
    check("drain_exit_ready", 96'(note_ready), 96'd1);

    vecs.push_back(mk(0, 1, 24'h001000, 1, 4'b0001, 0, 0, 0, 24'h001000));
    vecs.push_back(mk(0, 1, 24'h002000, 1, 4'b0011, 0, 0, 24'h002000, 24'h001000));
    vecs.push_back(mk(0, 0, 24'h002000, 1, 4'b0001, 0, 0, 24'h002000, 24'h001000));
    vecs.push_back(mk(0, 0, 24'h00ABCD, 0, 4'b0001, 0, 0, 24'h002000, 24'h001000));
    vecs.push_back(mk(1, 1, 24'h10, 1, 4'b0001, 0, 0, 0, 24'h10));
    vecs.push_back(mk(0, 1, 24'h20, 1, 4'b0011, 0, 0, 24'h20, 24'h10));
    vecs.push_back(mk(0, 1, 24'h30, 1, 4'b0111, 0, 24'h30, 24'h20, 24'h10));
    vecs.push_back(mk(0, 1, 24'h40, 1, 4'b1111, 24'h40, 24'h30, 24'h20, 24'h10));
`ifdef VOICE_STEAL_EN
    vecs.push_back(mk(0, 1, 24'h50, 1, 4'b1111, 24'h40, 24'h30, 24'h20, 24'h50));
`else
    vecs.push_back(mk(0, 1, 24'h50, 0, 4'b1111, 24'h40, 24'h30, 24'h20, 24'h10));
`endif
    vecs.push_back(mk(1, 1, 24'h10, 1, 4'b0001, 0, 0, 0, 24'h10));
    vecs.push_back(mk(0, 1, 24'h20, 1, 4'b0011, 0, 0, 24'h20, 24'h10));
    vecs.push_back(mk(0, 1, 24'h30, 1, 4'b0111, 0, 24'h30, 24'h20, 24'h10));
    vecs.push_back(mk(0, 1, 24'h40, 1, 4'b1111, 24'h40, 24'h30, 24'h20, 24'h10));
    vecs.push_back(mk(0, 1, 24'h10, 1, 4'b1111, 24'h40, 24'h30, 24'h20, 24'h10));
`ifdef VOICE_STEAL_EN
    vecs.push_back(mk(0, 1, 24'h50, 1, 4'b1111, 24'h40, 24'h30, 24'h50, 24'h10));
    vecs.push_back(mk(0, 0, 24'h30, 1, 4'b1011, 24'h40, 24'h30, 24'h50, 24'h10));
    vecs.push_back(mk(0, 1, 24'h60, 1, 4'b1111, 24'h40, 24'h60, 24'h50, 24'h10));
    vecs.push_back(mk(0, 1, 24'h70, 1, 4'b1111, 24'h70, 24'h60, 24'h50, 24'h10));
`else
    vecs.push_back(mk(0, 1, 24'h50, 0, 4'b1111, 24'h40, 24'h30, 24'h20, 24'h10));
    vecs.push_back(mk(0, 0, 24'h30, 1, 4'b1011, 24'h40, 24'h30, 24'h20, 24'h10));
    vecs.push_back(mk(0, 1, 24'h60, 1, 4'b1111, 24'h40, 24'h60, 24'h20, 24'h10));
    vecs.push_back(mk(0, 1, 24'h70, 0, 4'b1111, 24'h40, 24'h60, 24'h20, 24'h10));
`endif

    for (int k = 0; k < vecs.size(); k++) begin
      if (vecs[k].rst_before) do_reset();
      do_event(vecs[k].on, vecs[k].fcw, gr, gd);
      check($sformatf("v%0d_req", k), 96'(gr), 96'(vecs[k].upd));
      check($sformatf("v%0d_drop", k), 96'(gd), 96'(!vecs[k].upd));
      check($sformatf("v%0d_en", k), 96'(note_en), 96'(vecs[k].en));
      check($sformatf("v%0d_fcws", k), carrier_fcws, vecs[k].fcws);
    end

    // Reset while in REQ: outputs clear asynchronously, next event waits for ack low.
    do_reset();
    do_event(1'b1, 24'h001000, gr, gd);
    begin
      int n = 0;
      while (!note_ready && n < 30) begin @(posedge clk); #1; n++; end
    end
    check("mid_ready", 96'(note_ready), 96'd1);
    note_valid = 1'b1; note_on = 1'b1; note_fcw = 24'h002000;
    @(posedge clk); #1;
    note_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_req_high", 96'(req), 96'd1);
    check("mid_en", 96'(note_en), 96'b0011);
    ack = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async_req", 96'(req), 96'd0);
    check("async_en", 96'(note_en), 96'd0);
    check("async_fcws", carrier_fcws, 96'd0);
    check("async_ready", 96'(note_ready), 96'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_drain_ready", 96'(note_ready), 96'd0);
    ack = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", 96'(note_ready), 96'd1);
    do_event(1'b1, 24'h003000, gr, gd);
    check("post_rst_req", 96'(gr), 96'd1);
    check("post_rst_en", 96'(note_en), 96'b0001);
    check("post_rst_fcws", carrier_fcws, {72'd0, 24'h003000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
